// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//
// Purpose:
//   Carries the decode-stage control fields of the 5-stage RV32I core through
//   the Execute, Memory and Writeback pipeline registers. Each stage holds a
//   valid bit and the destination register. Each stage can also be held
//   (stall) or turned into a bubble (flush) by the hazard unit.
//
//   A bubble is a stage with every field at zero, so it has no side effects.
//   Every output is driven directly by a flop. No input reaches an output
//   combinationally.
//
// Stall/flush semantics:
//   holdM = StallM
//   holdE = StallE | StallM
//     Holds propagate backwards, so no instruction is lost while M is held.
//   E : FlushE -> bubble, else holdE -> keep, else load D (a bubble if !ValidD)
//   M : FlushM -> bubble, else holdM -> keep, else load the pre-edge E fields
//   W : holdM  -> bubble (so an instruction never retires twice), else load M
//   Flush wins over stall when both hit the same stage on the same edge.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   *D                decode-stage control fields from the main controller
//   StallE, FlushE    hazard-unit controls for the E register
//   StallM, FlushM    hazard-unit controls for the M register
//   *E                E-stage fields (to the EX datapath and hazard unit)
//   *M                M-stage fields (to the data memory and forwarding)
//   *W                W-stage fields (to the writeback mux and forwarding)
//
// Optional feature (macro CTRL_PIPE_PERF_EN):
//   instretCnt  counts edges that leave a valid instruction in W
//   bubbleCnt   counts bubbles inserted: +1 for FlushE, +1 for holdM
//   Both counters are 32 bits and wrap.
// ---------------------------------------------------------------------------
module ctrl_pipe #(
    parameter int RD_W   = 5,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    // decode-stage fields
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              ALUSrcD,
    input  logic              SrcAsrcD,
    input  logic              jumpRegD,
    input  logic [2:0]        funct3D,
    input  logic [RD_W-1:0]   RdD,
    // hazard controls
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              StallM,
    input  logic              FlushM,
    // E stage
    output logic              ValidE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcE,
    output logic              SrcAsrcE,
    output logic              jumpRegE,
    output logic [2:0]        funct3E,
    output logic [RD_W-1:0]   RdE,
    // M stage
    output logic              ValidM,
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              MemWriteM,
    output logic [2:0]        funct3M,
    output logic [RD_W-1:0]   RdM,
    // W stage
    output logic              ValidW,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [RD_W-1:0]   RdW
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]       instretCnt,
    output logic [31:0]       bubbleCnt
`endif
);

    logic hold_e;
    logic hold_m;

    assign hold_m = StallM;
    assign hold_e = StallE | StallM;

    // ---------------- E register ----------------
    logic              valid_e_d,       valid_e_q;
    logic              reg_write_e_d,   reg_write_e_q;
    logic [1:0]        result_src_e_d,  result_src_e_q;
    logic              mem_write_e_d,   mem_write_e_q;
    logic              jump_e_d,        jump_e_q;
    logic              branch_e_d,      branch_e_q;
    logic [ALUC_W-1:0] alu_control_e_d, alu_control_e_q;
    logic              alu_src_e_d,     alu_src_e_q;
    logic              src_a_src_e_d,   src_a_src_e_q;
    logic              jump_reg_e_d,    jump_reg_e_q;
    logic [2:0]        funct3_e_d,      funct3_e_q;
    logic [RD_W-1:0]   rd_e_d,          rd_e_q;

    always_comb begin
        // Bubble by default: covers FlushE and a non-valid decode slot.
        valid_e_d       = 1'b0;
        reg_write_e_d   = 1'b0;
        result_src_e_d  = '0;
        mem_write_e_d   = 1'b0;
        jump_e_d        = 1'b0;
        branch_e_d      = 1'b0;
        alu_control_e_d = '0;
        alu_src_e_d     = 1'b0;
        src_a_src_e_d   = 1'b0;
        jump_reg_e_d    = 1'b0;
        funct3_e_d      = '0;
        rd_e_d          = '0;
        if (!FlushE) begin
            if (hold_e) begin
                valid_e_d       = valid_e_q;
                reg_write_e_d   = reg_write_e_q;
                result_src_e_d  = result_src_e_q;
                mem_write_e_d   = mem_write_e_q;
                jump_e_d        = jump_e_q;
                branch_e_d      = branch_e_q;
                alu_control_e_d = alu_control_e_q;
                alu_src_e_d     = alu_src_e_q;
                src_a_src_e_d   = src_a_src_e_q;
                jump_reg_e_d    = jump_reg_e_q;
                funct3_e_d      = funct3_e_q;
                rd_e_d          = rd_e_q;
            end else if (ValidD) begin
                valid_e_d       = 1'b1;
                reg_write_e_d   = RegWriteD;
                result_src_e_d  = ResultSrcD;
                mem_write_e_d   = MemWriteD;
                jump_e_d        = JumpD;
                branch_e_d      = BranchD;
                alu_control_e_d = ALUControlD;
                alu_src_e_d     = ALUSrcD;
                src_a_src_e_d   = SrcAsrcD;
                jump_reg_e_d    = jumpRegD;
                funct3_e_d      = funct3D;
                rd_e_d          = RdD;
            end
        end
    end

    // ---------------- M register ----------------
    logic            valid_m_d,      valid_m_q;
    logic            reg_write_m_d,  reg_write_m_q;
    logic [1:0]      result_src_m_d, result_src_m_q;
    logic            mem_write_m_d,  mem_write_m_q;
    logic [2:0]      funct3_m_d,     funct3_m_q;
    logic [RD_W-1:0] rd_m_d,         rd_m_q;

    always_comb begin
        valid_m_d      = 1'b0;
        reg_write_m_d  = 1'b0;
        result_src_m_d = '0;
        mem_write_m_d  = 1'b0;
        funct3_m_d     = '0;
        rd_m_d         = '0;
        if (!FlushM) begin
            if (hold_m) begin
                valid_m_d      = valid_m_q;
                reg_write_m_d  = reg_write_m_q;
                result_src_m_d = result_src_m_q;
                mem_write_m_d  = mem_write_m_q;
                funct3_m_d     = funct3_m_q;
                rd_m_d         = rd_m_q;
            end else begin
                // Reads the E flops, so a same-edge FlushE does not affect it.
                valid_m_d      = valid_e_q;
                reg_write_m_d  = reg_write_e_q;
                result_src_m_d = result_src_e_q;
                mem_write_m_d  = mem_write_e_q;
                funct3_m_d     = funct3_e_q;
                rd_m_d         = rd_e_q;
            end
        end
    end

    // ---------------- W register ----------------
    logic            valid_w_d,      valid_w_q;
    logic            reg_write_w_d,  reg_write_w_q;
    logic [1:0]      result_src_w_d, result_src_w_q;
    logic [RD_W-1:0] rd_w_d,         rd_w_q;

    always_comb begin
        // W never stalls. While M holds, W takes a bubble so that the held
        // instruction retires only once, after it leaves M.
        valid_w_d      = 1'b0;
        reg_write_w_d  = 1'b0;
        result_src_w_d = '0;
        rd_w_d         = '0;
        if (!hold_m) begin
            valid_w_d      = valid_m_q;
            reg_write_w_d  = reg_write_m_q;
            result_src_w_d = result_src_m_q;
            rd_w_d         = rd_m_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_e_q       <= 1'b0;
            reg_write_e_q   <= 1'b0;
            result_src_e_q  <= '0;
            mem_write_e_q   <= 1'b0;
            jump_e_q        <= 1'b0;
            branch_e_q      <= 1'b0;
            alu_control_e_q <= '0;
            alu_src_e_q     <= 1'b0;
            src_a_src_e_q   <= 1'b0;
            jump_reg_e_q    <= 1'b0;
            funct3_e_q      <= '0;
            rd_e_q          <= '0;
            valid_m_q       <= 1'b0;
            reg_write_m_q   <= 1'b0;
            result_src_m_q  <= '0;
            mem_write_m_q   <= 1'b0;
            funct3_m_q      <= '0;
            rd_m_q          <= '0;
            valid_w_q       <= 1'b0;
            reg_write_w_q   <= 1'b0;
            result_src_w_q  <= '0;
            rd_w_q          <= '0;
        end else begin
            valid_e_q       <= valid_e_d;
            reg_write_e_q   <= reg_write_e_d;
            result_src_e_q  <= result_src_e_d;
            mem_write_e_q   <= mem_write_e_d;
            jump_e_q        <= jump_e_d;
            branch_e_q      <= branch_e_d;
            alu_control_e_q <= alu_control_e_d;
            alu_src_e_q     <= alu_src_e_d;
            src_a_src_e_q   <= src_a_src_e_d;
            jump_reg_e_q    <= jump_reg_e_d;
            funct3_e_q      <= funct3_e_d;
            rd_e_q          <= rd_e_d;
            valid_m_q       <= valid_m_d;
            reg_write_m_q   <= reg_write_m_d;
            result_src_m_q  <= result_src_m_d;
            mem_write_m_q   <= mem_write_m_d;
            funct3_m_q      <= funct3_m_d;
            rd_m_q          <= rd_m_d;
            valid_w_q       <= valid_w_d;
            reg_write_w_q   <= reg_write_w_d;
            result_src_w_q  <= result_src_w_d;
            rd_w_q          <= rd_w_d;
        end
    end

    assign ValidE      = valid_e_q;
    assign RegWriteE   = reg_write_e_q;
    assign ResultSrcE  = result_src_e_q;
    assign MemWriteE   = mem_write_e_q;
    assign JumpE       = jump_e_q;
    assign BranchE     = branch_e_q;
    assign ALUControlE = alu_control_e_q;
    assign ALUSrcE     = alu_src_e_q;
    assign SrcAsrcE    = src_a_src_e_q;
    assign jumpRegE    = jump_reg_e_q;
    assign funct3E     = funct3_e_q;
    assign RdE         = rd_e_q;
    assign ValidM      = valid_m_q;
    assign RegWriteM   = reg_write_m_q;
    assign ResultSrcM  = result_src_m_q;
    assign MemWriteM   = mem_write_m_q;
    assign funct3M     = funct3_m_q;
    assign RdM         = rd_m_q;
    assign ValidW      = valid_w_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RdW         = rd_w_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] instret_cnt_d, instret_cnt_q;
    logic [31:0] bubble_cnt_d,  bubble_cnt_q;

    always_comb begin
        // valid_w_d is the post-edge ValidW.
        instret_cnt_d = instret_cnt_q + {31'd0, valid_w_d};
        // A flush of E and a hold of M on the same edge are two bubbles.
        bubble_cnt_d  = bubble_cnt_q + {31'd0, FlushE} + {31'd0, hold_m};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_cnt_q <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            instret_cnt_q <= instret_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign instretCnt = instret_cnt_q;
    assign bubbleCnt  = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
//
// Directed scenarios followed by randomized traffic for ctrl_pipe. The
// reference model treats each stage as one slot that holds a whole
// instruction record, and it moves records between slots using the
// stall/flush rules. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       j;
        logic       b;
        logic [3:0] aluc;
        logic       alusrc;
        logic       srca;
        logic       jr;
        logic [2:0] f3;
        logic [4:0] rd;
    } ctl_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    ctl_t d_in;
    logic StallE, FlushE, StallM, FlushM;

    logic       ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, SrcAsrcE, jumpRegE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [2:0] funct3E;
    logic [4:0] RdE;
    logic       ValidM, RegWriteM, MemWriteM;
    logic [1:0] ResultSrcM;
    logic [2:0] funct3M;
    logic [4:0] RdM;
    logic       ValidW, RegWriteW;
    logic [1:0] ResultSrcW;
    logic [4:0] RdW;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] instretCnt, bubbleCnt;
`endif

    ctrl_pipe dut (
        .clk(clk), .reset(reset),
        .ValidD(d_in.valid), .RegWriteD(d_in.rw), .ResultSrcD(d_in.rs),
        .MemWriteD(d_in.mw), .JumpD(d_in.j), .BranchD(d_in.b),
        .ALUControlD(d_in.aluc), .ALUSrcD(d_in.alusrc), .SrcAsrcD(d_in.srca),
        .jumpRegD(d_in.jr), .funct3D(d_in.f3), .RdD(d_in.rd),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .SrcAsrcE(SrcAsrcE),
        .jumpRegE(jumpRegE), .funct3E(funct3E), .RdE(RdE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M), .RdM(RdM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW)
`ifdef CTRL_PIPE_PERF_EN
        , .instretCnt(instretCnt), .bubbleCnt(bubbleCnt)
`endif
    );

    // ---------------- reference model ----------------
    ctl_t mdl_e, mdl_m, mdl_w;
    logic [31:0] mdl_inst, mdl_bub;

    // Only the fields carried beyond E survive the move into M.
    function automatic ctl_t keep_m(ctl_t x);
        ctl_t r = '0;
        r.valid = x.valid; r.rw = x.rw; r.rs = x.rs; r.mw = x.mw; r.f3 = x.f3; r.rd = x.rd;
        return r;
    endfunction

    // Only the fields carried into W survive the move out of M.
    function automatic ctl_t keep_w(ctl_t x);
        ctl_t r = '0;
        r.valid = x.valid; r.rw = x.rw; r.rs = x.rs; r.rd = x.rd;
        return r;
    endfunction

    task automatic model_reset();
        mdl_e = '0; mdl_m = '0; mdl_w = '0; mdl_inst = 0; mdl_bub = 0;
    endtask

    task automatic model_edge();
        ctl_t ne, nm, nw;
        if (FlushE)                ne = '0;
        else if (StallE || StallM) ne = mdl_e;
        else                       ne = d_in.valid ? d_in : '0;
        if (FlushM)      nm = '0;
        else if (StallM) nm = mdl_m;
        else             nm = keep_m(mdl_e);
        nw = StallM ? '0 : keep_w(mdl_m);
        mdl_inst = mdl_inst + (nw.valid ? 32'd1 : 32'd0);
        mdl_bub  = mdl_bub + (FlushE ? 32'd1 : 32'd0) + (StallM ? 32'd1 : 32'd0);
        mdl_e = ne; mdl_m = nm; mdl_w = nw;
    endtask

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ctl_t oe, om, ow;
        oe = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
              ALUControlE, ALUSrcE, SrcAsrcE, jumpRegE, funct3E, RdE};
        om = '0;
        om.valid = ValidM; om.rw = RegWriteM; om.rs = ResultSrcM;
        om.mw = MemWriteM; om.f3 = funct3M; om.rd = RdM;
        ow = '0;
        ow.valid = ValidW; ow.rw = RegWriteW; ow.rs = ResultSrcW; ow.rd = RdW;
        chk("stage_e", {10'd0, oe}, {10'd0, mdl_e});
        chk("stage_m", {10'd0, om}, {10'd0, mdl_m});
        chk("stage_w", {10'd0, ow}, {10'd0, mdl_w});
`ifdef CTRL_PIPE_PERF_EN
        chk("instret_cnt", instretCnt, mdl_inst);
        chk("bubble_cnt",  bubbleCnt,  mdl_bub);
`endif
    endtask

    // One clock edge: the model follows the edge, outputs are checked on the
    // following falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        check_all();
    endtask

    // ---------------- driver helpers ----------------
    function automatic ctl_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                input logic [2:0] f3, input logic [4:0] rd);
        ctl_t r = '0;
        r.valid = 1'b1; r.rw = rw; r.rs = rs; r.mw = mw; r.f3 = f3; r.rd = rd;
        r.aluc = 4'd2;
        return r;
    endfunction

    task automatic clear_hazards();
        StallE = 0; FlushE = 0; StallM = 0; FlushM = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        reset = 1'b1;
        d_in  = '0;
        clear_hazards();
        model_reset();
        repeat (2) tick();
        chk("reset_valid_w", {31'd0, ValidW}, 32'd0);
        reset = 1'b0;

        // Straight flow: one instruction reaches W after three edges.
        d_in = mk(1'b1, 2'b01, 1'b0, 3'd0, 5'd5);
        tick();
        d_in = '0;
        chk("flow_regwrite_e", {31'd0, RegWriteE}, 32'd1);
        tick();
        chk("flow_rd_m", {27'd0, RdM}, 32'd5);
        tick();
        chk("flow_w", {24'd0, RegWriteW, ResultSrcW, RdW}, {24'd0, 1'b1, 2'b01, 5'd5});
        tick();
        chk("flow_w_gone", {31'd0, RegWriteW}, 32'd0);

        // Load-use bubble: flush beats stall on E, and E's old contents move on.
        d_in = mk(1'b1, 2'b00, 1'b0, 3'd0, 5'd3);
        tick();
        d_in = mk(1'b0, 2'b00, 1'b1, 3'd2, 5'd9);
        FlushE = 1; StallE = 1;
        tick();
        clear_hazards();
        d_in = '0;
        chk("lu_e_bubble", {30'd0, ValidE, MemWriteE}, 32'd0);
        chk("lu_m_took_e", {26'd0, ValidM, RdM}, {26'd0, 1'b1, 5'd3});

        // Memory stall: a store in M and an ALU op in E hold for two edges.
        d_in = mk(1'b0, 2'b00, 1'b1, 3'd2, 5'd0);
        tick();
        d_in = mk(1'b1, 2'b00, 1'b0, 3'd0, 5'd7);
        tick();
        d_in = '0;
        StallM = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ms_w_bubble", {31'd0, ValidW}, 32'd0);
            chk("ms_hold", {25'd0, MemWriteM, RdM, RdE}, {25'd0, 1'b1, 5'd0, 5'd7});
        end
        StallM = 0;
        tick();
        chk("ms_release_w", {26'd0, ValidW, RdW}, {26'd0, 1'b1, 5'd0});
        chk("ms_release_m", {26'd0, RegWriteM, RdM}, {26'd0, 1'b1, 5'd7});

        // Branch flush: E and M squashed together, W takes the old M.
        for (int i = 11; i <= 13; i++) begin
            d_in = mk(1'b1, 2'b10, 1'b0, 3'd0, 5'(i));
            tick();
        end
        d_in = '0;
        FlushE = 1; FlushM = 1;
        tick();
        clear_hazards();
        chk("bf_e_m_bubble", {30'd0, ValidE, ValidM}, 32'd0);
        chk("bf_w_old_m", {26'd0, ValidW, RdW}, {26'd0, 1'b1, 5'd12});

        // Async reset between edges while M is stalled and every stage is valid.
        for (int i = 20; i <= 22; i++) begin
            d_in = mk(1'b1, 2'b00, 1'b0, 3'd1, 5'(i));
            tick();
        end
        StallM = 1;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        chk("ar_valid_all", {29'd0, ValidE, ValidM, ValidW}, 32'd0);
        tick();
        chk("ar_held_rd", {17'd0, RdE, RdM, RdW}, 32'd0);
        reset = 1'b0;
        clear_hazards();
        d_in = '0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            d_in = r[21:0];
            StallE = ($urandom_range(0, 5) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            StallM = ($urandom_range(0, 6) == 0);
            FlushM = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
